// File: rtl/wifi_payload_streamer_if.sv
// Byte/handshake bundle between the payload streamer, its external byte source
// and the wifi core. The streamer side is the master.
interface wifi_payload_streamer_if;
    logic [7:0] ext_data;
    logic       ext_valid;
    logic       ext_ready;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_accepted;
    logic       data_end;
    logic       sendPOST;
    logic       start;

    modport master (
        input  ext_data, ext_valid, data_accepted,
        output ext_ready, data_in, data_in_valid, data_end, sendPOST, start
    );

    modport slave (
        output ext_data, ext_valid, data_accepted,
        input  ext_ready, data_in, data_in_valid, data_end, sendPOST, start
    );
endinterface

// File: rtl/wifi_payload_streamer.sv
// Streams fixed-length payload records (fill byte or external bytes) to a wifi core,
// closing each record with an end strobe and a POST request, plus a BCD table number.
module wifi_payload_streamer #(
    parameter int         PAYLOAD_LEN = 220,
    parameter int         NUM_RECORDS = 1,
    parameter logic [7:0] FILL_BYTE   = 8'h46,
    parameter int         DIGITS      = 2
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    go,
    input  logic                    mode,
    wifi_payload_streamer_if.master bus,
    input  logic                    increment_table_number,
    output logic [8*DIGITS-1:0]     table_number_ascii,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              state_code
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_END    = 3'd2,
        ST_POST   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [15:0] LAST_BYTE = 16'(PAYLOAD_LEN - 1);
    localparam logic [7:0]  LAST_REC  = 8'(NUM_RECORDS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_byte_idx;
    logic [15:0]         w_byte_idx_next;
    logic [7:0]          r_rec_idx;
    logic [7:0]          w_rec_idx_next;
    logic                r_mode;
    logic                w_mode_next;
    logic [4*DIGITS-1:0] r_bcd;
    logic [4*DIGITS-1:0] w_bcd_inc;
    logic [4*DIGITS-1:0] w_bcd_next;
    logic [8*DIGITS-1:0] r_ascii;
    logic [8*DIGITS-1:0] w_ascii_next;
    logic [DIGITS-1:0]   w_carry;
    logic                w_clear_tn;

    logic [7:0]          w_data_in;
    logic                w_data_in_valid;
    logic                w_ext_ready;
    logic                w_data_end;
    logic                w_send_post;
    logic                w_start;

    always_comb begin
        w_state_next    = r_state;
        w_byte_idx_next = r_byte_idx;
        w_rec_idx_next  = r_rec_idx;
        w_mode_next     = r_mode;
        w_clear_tn      = 1'b0;
        w_data_in       = 8'h00;
        w_data_in_valid = 1'b0;
        w_ext_ready     = 1'b0;
        w_data_end      = 1'b0;
        w_send_post     = 1'b0;
        w_start         = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    w_state_next    = ST_STREAM;
                    w_byte_idx_next = '0;
                    w_rec_idx_next  = '0;
                    w_mode_next     = mode;
                    w_clear_tn      = 1'b1;
                end
            end

            ST_STREAM: begin
                w_start = 1'b1;
                if (r_mode) begin
                    w_data_in       = bus.ext_data;
                    w_data_in_valid = bus.ext_valid;
                    w_ext_ready     = bus.data_accepted & bus.ext_valid;
                end else begin
                    w_data_in       = FILL_BYTE;
                    w_data_in_valid = 1'b1;
                end
                // The beat that completes the record leaves the index at its last value;
                // it is cleared when the POST for this record is accepted.
                if (w_data_in_valid && bus.data_accepted) begin
                    if (r_byte_idx == LAST_BYTE) begin
                        w_state_next = ST_END;
                    end else begin
                        w_byte_idx_next = r_byte_idx + 16'd1;
                    end
                end
            end

            ST_END: begin
                w_data_end   = 1'b1;
                w_state_next = ST_POST;
            end

            ST_POST: begin
                w_send_post     = 1'b1;
                w_data_in_valid = 1'b1;
                w_start         = 1'b1;
                if (bus.data_accepted) begin
                    if (r_rec_idx < LAST_REC) begin
                        w_rec_idx_next  = r_rec_idx + 8'd1;
                        w_byte_idx_next = '0;
                        w_state_next    = ST_STREAM;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Decimal table number: each digit steps only when every lower digit wraps 9 -> 0.
    assign w_carry[0] = increment_table_number &
                        ((r_state == ST_STREAM) | (r_state == ST_POST));

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_digit;
            assign w_digit = r_bcd[4*gi +: 4];
            assign w_bcd_inc[4*gi +: 4] = !w_carry[gi]       ? w_digit :
                                          (w_digit == 4'd9)  ? 4'd0    :
                                                               w_digit + 4'd1;
            assign w_ascii_next[8*gi +: 8] = {4'h3, w_bcd_next[4*gi +: 4]};
            if (gi < DIGITS - 1) begin : g_ripple
                assign w_carry[gi+1] = w_carry[gi] & (w_digit == 4'd9);
            end
        end
    endgenerate

    assign w_bcd_next = w_clear_tn ? '0 : w_bcd_inc;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_byte_idx <= '0;
            r_rec_idx  <= '0;
            r_mode     <= 1'b0;
            r_bcd      <= '0;
            r_ascii    <= {DIGITS{8'h30}};
        end else begin
            r_state    <= w_state_next;
            r_byte_idx <= w_byte_idx_next;
            r_rec_idx  <= w_rec_idx_next;
            r_mode     <= w_mode_next;
            r_bcd      <= w_bcd_next;
            r_ascii    <= w_ascii_next;
        end
    end

    assign bus.data_in         = w_data_in;
    assign bus.data_in_valid   = w_data_in_valid;
    assign bus.ext_ready       = w_ext_ready;
    assign bus.data_end        = w_data_end;
    assign bus.sendPOST        = w_send_post;
    assign bus.start           = w_start;

    assign table_number_ascii  = r_ascii;
    assign busy                = (r_state == ST_STREAM) || (r_state == ST_END) || (r_state == ST_POST);
    assign done                = (r_state == ST_DONE);
    assign state_code          = r_state;

endmodule

// File: tb/tb_wifi_payload_streamer.sv
// Three streamer instances (220x1, 4x3, 1x1 with 3 digits) share one stimulus stream
// and are checked every cycle against a count-based reference model.
module tb_wifi_payload_streamer;
    localparam int NI = 3;

    int         m_len  [NI] = '{220, 4, 1};
    int         m_nrec [NI] = '{1, 3, 1};
    int         m_dig  [NI] = '{2, 2, 3};
    logic [7:0] m_fill [NI] = '{8'h46, 8'h46, 8'hA5};

    // Reference model: run flag, latched mode, cumulative bytes/POSTs this run, END flag, table number.
    bit m_run   [NI];
    bit m_mode  [NI];
    int m_bytes [NI];
    int m_posts [NI];
    bit m_endf  [NI];
    int m_tn    [NI];

    int obs_bytes [NI];
    int obs_ends  [NI];
    int obs_posts [NI];
    int obs_ready [NI];

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc_no = 0;
    bit chk_en = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, go, mode_in, acc, inc, ev;
    logic [7:0] ed;

    wifi_payload_streamer_if if_a ();
    wifi_payload_streamer_if if_b ();
    wifi_payload_streamer_if if_c ();

    assign if_a.ext_data = ed;  assign if_a.ext_valid = ev;  assign if_a.data_accepted = acc;
    assign if_b.ext_data = ed;  assign if_b.ext_valid = ev;  assign if_b.data_accepted = acc;
    assign if_c.ext_data = ed;  assign if_c.ext_valid = ev;  assign if_c.data_accepted = acc;

    logic [15:0] asc_a, asc_b;
    logic [23:0] asc_c;
    logic [2:0]  sc_a, sc_b, sc_c;
    logic [2:0]  busy_v, done_v;

    wifi_payload_streamer dut_a (
        .CLOCK_50(clk), .reset(rst_n), .go(go), .mode(mode_in), .bus(if_a),
        .increment_table_number(inc), .table_number_ascii(asc_a),
        .busy(busy_v[0]), .done(done_v[0]), .state_code(sc_a)
    );

    wifi_payload_streamer #(.PAYLOAD_LEN(4), .NUM_RECORDS(3)) dut_b (
        .CLOCK_50(clk), .reset(rst_n), .go(go), .mode(mode_in), .bus(if_b),
        .increment_table_number(inc), .table_number_ascii(asc_b),
        .busy(busy_v[1]), .done(done_v[1]), .state_code(sc_b)
    );

    wifi_payload_streamer #(.PAYLOAD_LEN(1), .NUM_RECORDS(1), .FILL_BYTE(8'hA5), .DIGITS(3)) dut_c (
        .CLOCK_50(clk), .reset(rst_n), .go(go), .mode(mode_in), .bus(if_c),
        .increment_table_number(inc), .table_number_ascii(asc_c),
        .busy(busy_v[2]), .done(done_v[2]), .state_code(sc_c)
    );

    typedef struct {
        logic [31:0] asc;
        logic [2:0]  sc;
        logic        busy, done, dv, de, sp, st, er;
        logic [7:0]  di;
    } obs_t;

    typedef struct {
        int          pulses;
        logic [15:0] exp_b;
        logic [23:0] exp_c;
    } tn_vec_t;

    function automatic obs_t observe(input int k);
        obs_t o;
        case (k)
            0: begin
                o.asc = {16'h0, asc_a}; o.sc = sc_a; o.busy = busy_v[0]; o.done = done_v[0];
                o.dv = if_a.data_in_valid; o.de = if_a.data_end; o.sp = if_a.sendPOST;
                o.st = if_a.start; o.er = if_a.ext_ready; o.di = if_a.data_in;
            end
            1: begin
                o.asc = {16'h0, asc_b}; o.sc = sc_b; o.busy = busy_v[1]; o.done = done_v[1];
                o.dv = if_b.data_in_valid; o.de = if_b.data_end; o.sp = if_b.sendPOST;
                o.st = if_b.start; o.er = if_b.ext_ready; o.di = if_b.data_in;
            end
            default: begin
                o.asc = {8'h0, asc_c}; o.sc = sc_c; o.busy = busy_v[2]; o.done = done_v[2];
                o.dv = if_c.data_in_valid; o.de = if_c.data_end; o.sp = if_c.sendPOST;
                o.st = if_c.start; o.er = if_c.ext_ready; o.di = if_c.data_in;
            end
        endcase
        return o;
    endfunction

    // 0 idle, 1 stream, 2 end, 3 post, 4 done -- derived purely from counts.
    function automatic int phase(input int k);
        if (!m_run[k])                                 return 0;
        if (m_endf[k])                                 return 2;
        if (m_posts[k] == m_nrec[k])                   return 4;
        if (m_bytes[k] == (m_posts[k] + 1) * m_len[k]) return 3;
        return 1;
    endfunction

    function automatic logic [31:0] ascii_of(input int n, input int dig);
        logic [31:0] r;
        int          v;
        r = '0;
        v = n;
        for (int d = 0; d < dig; d++) begin
            r[8*d +: 8] = 8'h30 + 8'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cycle %0d: got %0h, want %0h", nm, k, cyc_no, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input int k, input logic act, input logic exp);
        chk(nm, k, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic zero_obs();
        for (int k = 0; k < NI; k++) begin
            obs_bytes[k] = 0; obs_ends[k] = 0; obs_posts[k] = 0; obs_ready[k] = 0;
        end
    endtask

    task automatic cyc(input logic r, input logic g, input logic m, input logic a,
                       input logic i, input logic v, input logic [7:0] d);
        @(negedge clk);
        rst_n = r; go = g; mode_in = m; acc = a; inc = i; ev = v; ed = d;
        #1;
        for (int k = 0; k < NI; k++) begin
            int   p;
            obs_t o;
            logic vld;
            p   = phase(k);
            o   = observe(k);
            vld = (p == 1) ? (m_mode[k] ? v : 1'b1) : (p == 3);
            if (chk_en) begin
                chk("state_code", k, {29'b0, o.sc}, 32'(p));
                chk1("busy", k, o.busy, (p >= 1) && (p <= 3));
                chk1("done", k, o.done, p == 4);
                chk1("data_in_valid", k, o.dv, vld);
                chk("data_in", k, {24'b0, o.di},
                    {24'b0, (p == 1) ? (m_mode[k] ? d : m_fill[k]) : 8'h00});
                chk1("ext_ready", k, o.er, (p == 1) && m_mode[k] && v && a);
                chk1("data_end", k, o.de, p == 2);
                chk1("sendPOST", k, o.sp, p == 3);
                chk1("start", k, o.st, (p == 1) || (p == 3));
                chk("ascii", k, o.asc, ascii_of(m_tn[k], m_dig[k]));
            end
            if (o.dv === 1'b1 && a && o.st === 1'b1 && o.sp === 1'b0) obs_bytes[k]++;
            if (o.de === 1'b1)                                       obs_ends[k]++;
            if (o.sp === 1'b1 && a)                                  obs_posts[k]++;
            if (o.er === 1'b1)                                       obs_ready[k]++;

            if (!r) begin
                m_run[k] = 0; m_mode[k] = 0; m_bytes[k] = 0; m_posts[k] = 0; m_endf[k] = 0; m_tn[k] = 0;
            end else begin
                case (p)
                    0, 4: if (g) begin
                        m_run[k] = 1; m_mode[k] = m; m_bytes[k] = 0; m_posts[k] = 0;
                        m_endf[k] = 0; m_tn[k] = 0;
                    end
                    1: begin
                        if (vld && a) begin
                            m_bytes[k]++;
                            if (m_bytes[k] % m_len[k] == 0) m_endf[k] = 1;
                        end
                        if (i) m_tn[k] = (m_tn[k] + 1) % (10 ** m_dig[k]);
                    end
                    2: m_endf[k] = 0;
                    3: begin
                        if (a) m_posts[k]++;
                        if (i) m_tn[k] = (m_tn[k] + 1) % (10 ** m_dig[k]);
                    end
                    default: ;
                endcase
            end
        end
        cyc_no++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog dut0 cycle %0d: got timeout, want finish", cyc_no);
        $fatal(1, "timeout");
    end

    initial begin
        tn_vec_t tv [6];
        tv[0] = '{1,  16'h3031, 24'h303031};
        tv[1] = '{8,  16'h3039, 24'h303039};
        tv[2] = '{1,  16'h3130, 24'h303130};
        tv[3] = '{89, 16'h3939, 24'h303939};
        tv[4] = '{1,  16'h3030, 24'h313030};
        tv[5] = '{1,  16'h3031, 24'h313031};

        rst_n = 1'b0; go = 1'b0; mode_in = 1'b0; acc = 1'b0; inc = 1'b0; ev = 1'b0; ed = 8'h00;
        for (int j = 0; j < 3; j++) cyc(0, 0, 0, 0, 0, 0, 8'h00);
        chk_en = 1'b1;
        for (int j = 0; j < 2; j++) cyc(1, 0, 0, 0, 0, 0, 8'h00);

        // Fill-mode run with the core always accepting.
        zero_obs();
        cyc(1, 1, 0, 1, 0, 0, 8'h00);
        for (int j = 0; j < 240; j++) cyc(1, 0, 0, 1, 0, 0, 8'h00);
        chk("fill_bytes", 0, obs_bytes[0], 220);
        chk("fill_ends",  0, obs_ends[0], 1);
        chk("fill_posts", 0, obs_posts[0], 1);
        chk("fill_bytes", 1, obs_bytes[1], 12);
        chk("fill_ends",  1, obs_ends[1], 3);
        chk("fill_bytes", 2, obs_bytes[2], 1);
        chk1("fill_done", 0, done_v[0], 1'b1);
        chk("fill_state", 0, {29'b0, sc_a}, 32'd4);

        // Reset at byte 57, then a clean restart from byte 0.
        cyc(1, 1, 0, 1, 0, 0, 8'h00);
        for (int j = 0; j < 57; j++) cyc(1, 0, 0, 1, 0, 0, 8'h00);
        cyc(0, 1, 0, 1, 1, 1, 8'h00);
        @(posedge clk); #1;
        chk("abort_state", 0, {29'b0, sc_a}, 32'd0);
        chk("abort_ascii", 0, {16'h0, asc_a}, 32'h3030);
        chk1("abort_valid", 0, if_a.data_in_valid, 1'b0);
        chk1("abort_busy",  0, busy_v[0], 1'b0);
        zero_obs();
        cyc(1, 1, 0, 1, 0, 0, 8'h00);
        for (int j = 0; j < 240; j++) cyc(1, 0, 0, 1, 0, 0, 8'h00);
        chk("restart_bytes", 0, obs_bytes[0], 220);
        chk("restart_ends",  0, obs_ends[0], 1);

        // Table-number vectors while parked in STREAM.
        cyc(1, 1, 0, 0, 0, 0, 8'h00);
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < tv[r].pulses; j++) cyc(1, 0, 0, 0, 1, 0, 8'h00);
            @(posedge clk); #1;
            chk("tn_vec", 1, {16'h0, asc_b}, {16'h0, tv[r].exp_b});
            chk("tn_vec", 2, {8'h0, asc_c},  {8'h0, tv[r].exp_c});
        end

        // Last byte accepted together with an increment and a go.
        for (int j = 0; j < 3; j++) cyc(1, 0, 0, 1, 0, 0, 8'h00);
        cyc(1, 1, 0, 1, 1, 0, 8'h00);
        @(posedge clk); #1;
        chk("last_go_state", 1, {29'b0, sc_b}, 32'd2);
        chk("last_go_ascii", 1, {16'h0, asc_b}, 32'h3032);
        chk1("last_go_end",  1, if_b.data_end, 1'b1);
        for (int j = 0; j < 260; j++) cyc(1, 0, 0, 1, 0, 0, 8'h00);

        // External mode, ext_valid low every other cycle.
        zero_obs();
        cyc(1, 1, 1, 1, 0, 0, 8'h00);
        for (int j = 0; j < 500; j++) cyc(1, 0, 0, 1, 0, (j % 2) == 0, 8'($urandom));
        chk("ext_ready_cnt", 0, obs_ready[0], 220);
        chk("ext_bytes",     0, obs_bytes[0], 220);
        chk("ext_ready_cnt", 1, obs_ready[1], 12);
        chk("ext_ready_cnt", 2, obs_ready[2], 1);

        // Fill mode with random acceptance gaps.
        zero_obs();
        cyc(1, 1, 0, 1, 0, 0, 8'h00);
        for (int j = 0; j < 200; j++) cyc(1, 0, 0, $urandom_range(0, 2) != 0, 0, 0, 8'h00);
        chk("gap_bytes", 1, obs_bytes[1], 12);
        chk("gap_ends",  1, obs_ends[1], 3);
        chk("gap_posts", 1, obs_posts[1], 3);

        // Random soak against the model.
        for (int j = 0; j < 4000; j++)
            cyc($urandom_range(0, 299) != 0, $urandom_range(0, 19) == 0, 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
